// File: rtl/controller_pkg.sv
// Shared types and constants for the run-sequence controller.
// Holds the controller state enum, the drain terminal count and the uartsel codes.
// Imported by controller and drain_counter.
package controller_pkg;

  localparam int COUNT_W = 13;

  // Last value of the drain counter; a drain phase therefore lasts 8192 cycles.
  localparam logic [COUNT_W-1:0] DRAIN_MAX = 13'h1FFF;

  localparam logic [2:0] UARTSEL_IDLE = 3'd0;
  localparam logic [2:0] UARTSEL_FSM0 = 3'd1;
  localparam logic [2:0] UARTSEL_FSM1 = 3'd2;
  localparam logic [2:0] UARTSEL_DONE = 3'd3;

  typedef enum logic [2:0] {
    init      = 3'd0,
    startFSM0 = 3'd1,
    waitFSM0  = 3'd2,
    waituart0 = 3'd3,
    startFSM1 = 3'd4,
    waitFSM1  = 3'd5,
    waituart1 = 3'd6,
    finish    = 3'd7
  } ctrl_state_t;

endpackage

// File: rtl/drain_counter.sv
// Purpose: free-running drain counter with synchronous clear, enable and terminal-count flag.
// Latency: count updates one cycle after i_en; o_tc is combinational from the count.
// Backpressure: none; the counter advances on every enabled cycle.
// Ports: clk, reset (async active-high), i_clr (sync clear, wins over i_en),
//        i_en (increment), o_count (current value), o_tc (count == DRAIN_MAX).
module drain_counter
  import controller_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clr,
  input  logic               i_en,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_tc
);

  logic [COUNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == DRAIN_MAX);

endmodule

// File: rtl/controller.sv
// Purpose: sequences FSM0 launch/wait, a UART drain, FSM1 launch/wait, then reports done.
// Latency: one cycle per launch state; each drain phase lasts exactly 8192 cycles.
// Backpressure: waits indefinitely on doneFSM0/doneFSM1; start only sampled in init.
// Ports: clk, reset (async active-high), start, beginFSM0/doneFSM0, beginFSM1/doneFSM1,
//        uartsel[2:0] (UART source select), done (sequence complete).
// Config: define UART1_DRAIN_EN to add a second 8192-cycle drain (waituart1) after FSM1.
module controller
  import controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       beginFSM0,
  input  logic       doneFSM0,
  output logic       beginFSM1,
  input  logic       doneFSM1,
  output logic [2:0] uartsel,
  output logic       done
);

  ctrl_state_t        state;
  ctrl_state_t        w_next;
  logic [COUNT_W-1:0] count;
  logic               w_drain;
  logic               w_tc;

  // The counter is held at zero outside the drain states, so it is 0 on entry.
  assign w_drain = (state == waituart0) || (state == waituart1);

  drain_counter u_drain (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (!w_drain),
    .i_en    (w_drain),
    .o_count (count),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= init;
    end else begin
      state <= w_next;
    end
  end

  always_comb begin
    w_next    = state;
    beginFSM0 = 1'b0;
    beginFSM1 = 1'b0;
    done      = 1'b0;
    uartsel   = UARTSEL_IDLE;
    case (state)
      init: begin
        if (start) w_next = startFSM0;
      end
      startFSM0: begin
        beginFSM0 = 1'b1;
        uartsel   = UARTSEL_FSM0;
        w_next    = waitFSM0;
      end
      waitFSM0: begin
        uartsel = UARTSEL_FSM0;
        if (doneFSM0) w_next = waituart0;
      end
      waituart0: begin
        uartsel = UARTSEL_FSM0;
        if (w_tc) w_next = startFSM1;
      end
      startFSM1: begin
        beginFSM1 = 1'b1;
        uartsel   = UARTSEL_FSM1;
        w_next    = waitFSM1;
      end
      waitFSM1: begin
        uartsel = UARTSEL_FSM1;
`ifdef UART1_DRAIN_EN
        if (doneFSM1) w_next = waituart1;
`else
        if (doneFSM1) w_next = finish;
`endif
      end
      waituart1: begin
        // Only reachable with UART1_DRAIN_EN.
        uartsel = UARTSEL_FSM1;
        if (w_tc) w_next = finish;
      end
      finish: begin
        done    = 1'b1;
        uartsel = UARTSEL_DONE;
      end
      default: w_next = init;
    endcase
  end

endmodule

// File: tb/tb_controller.sv
module tb_controller;
  import controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       doneFSM0;
  logic       doneFSM1;
  logic       beginFSM0;
  logic       beginFSM1;
  logic       done;
  logic [2:0] uartsel;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  controller dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .beginFSM0 (beginFSM0),
    .doneFSM0  (doneFSM0),
    .beginFSM1 (beginFSM1),
    .doneFSM1  (doneFSM1),
    .uartsel   (uartsel),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase of the run plus number of cycles already spent draining.
  ctrl_state_t m_state;
  int          m_drained;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state   <= init;
      m_drained <= 0;
    end else begin
      case (m_state)
        init:      if (start) m_state <= startFSM0;
        startFSM0: m_state <= waitFSM0;
        waitFSM0:  if (doneFSM0) begin m_state <= waituart0; m_drained <= 0; end
        waituart0: begin
          if (m_drained == 8191) m_state <= startFSM1;
          else m_drained <= m_drained + 1;
        end
        startFSM1: m_state <= waitFSM1;
`ifdef UART1_DRAIN_EN
        waitFSM1:  if (doneFSM1) begin m_state <= waituart1; m_drained <= 0; end
`else
        waitFSM1:  if (doneFSM1) m_state <= finish;
`endif
        waituart1: begin
          if (m_drained == 8191) m_state <= finish;
          else m_drained <= m_drained + 1;
        end
        default:   m_state <= m_state;
      endcase
    end
  end

  function automatic logic [2:0] exp_uartsel(ctrl_state_t s);
    case (s)
      startFSM0, waitFSM0, waituart0: return 3'd1;
      startFSM1, waitFSM1, waituart1: return 3'd2;
      finish:                         return 3'd3;
      default:                        return 3'd0;
    endcase
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always begin
    @(posedge clk);
    #2;
    if (cmp_en && !reset) begin
      chk("model_state", dut.state, m_state);
      chk("model_begin0", beginFSM0, m_state == startFSM0);
      chk("model_begin1", beginFSM1, m_state == startFSM1);
      chk("model_done", done, m_state == finish);
      chk("model_uartsel", uartsel, exp_uartsel(m_state));
      if (m_state == waituart0 || m_state == waituart1)
        chk("model_count", dut.count, m_drained);
    end
  end

  task automatic wait_state(input string name, input ctrl_state_t s, input int budget);
    int n = 0;
    while (dut.state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, dut.state, s);
  endtask

  task automatic run_to_finish();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(1, 6)) @(negedge clk);
    doneFSM0 = 1'b1;
    @(negedge clk);
    doneFSM0 = 1'b0;
    wait_state("rerun_startFSM1", startFSM1, 9000);
    repeat ($urandom_range(1, 6)) @(negedge clk);
    doneFSM1 = 1'b1;
    @(negedge clk);
    doneFSM1 = 1'b0;
    wait_state("rerun_finish", finish, 9000);
    chk("rerun_done", done, 1'b1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; doneFSM0 = 1'b0; doneFSM1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // One-cycle reset while idle.
    reset = 1'b1;
    #1;
    chk("rst_state", dut.state, init);
    chk("rst_done", done, 1'b0);
    chk("rst_uartsel", uartsel, 3'd0);
    chk("rst_begin0", beginFSM0, 1'b0);
    chk("rst_begin1", beginFSM1, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Launch, then reset out of startFSM0.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("launch_state", dut.state, startFSM0);
    chk("launch_begin0", beginFSM0, 1'b1);
    chk("launch_uartsel", uartsel, 3'd1);
    reset = 1'b1;
    #1;
    chk("launch_rst_state", dut.state, init);
    @(negedge clk);
    reset = 1'b0;

    // Full sequence; stray doneFSM1/start while waiting on FSM0 must be ignored.
    start = 1'b1;
    @(negedge clk);
    doneFSM1 = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; doneFSM1 = 1'b0;
    chk("hold_waitFSM0", dut.state, waitFSM0);
    doneFSM0 = 1'b1;
    @(negedge clk);
    doneFSM0 = 1'b0;
    chk("enter_waituart0", dut.state, waituart0);
    chk("enter_count", dut.count, 13'd0);
    begin
      int n = 0;
      while (dut.count != 13'h1FFF && n < 9000) begin
        @(negedge clk);
        n++;
      end
    end
    chk("drain0_last_count", dut.count, 13'h1FFF);
    chk("drain0_last_state", dut.state, waituart0);
    @(negedge clk);
    chk("start1_state", dut.state, startFSM1);
    chk("start1_begin1", beginFSM1, 1'b1);
    chk("start1_uartsel", uartsel, 3'd2);
    @(negedge clk);
    chk("wait1_state", dut.state, waitFSM1);
    doneFSM1 = 1'b1;
    @(negedge clk);
    doneFSM1 = 1'b0;
`ifdef UART1_DRAIN_EN
    chk("enter_waituart1", dut.state, waituart1);
    chk("enter_count1", dut.count, 13'd0);
    wait_state("drain1_finish", finish, 9000);
`endif
    chk("finish_state", dut.state, finish);
    chk("finish_done", done, 1'b1);
    chk("finish_uartsel", uartsel, 3'd3);
    for (int i = 0; i < 10; i++) begin
      start = 1'($urandom); doneFSM0 = 1'($urandom); doneFSM1 = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0; doneFSM0 = 1'b0; doneFSM1 = 1'b0;
    chk("finish_hold", dut.state, finish);

    // Reset mid-drain, then a complete rerun.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    doneFSM0 = 1'b1;
    @(negedge clk);
    doneFSM0 = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_count", dut.count, 13'd100);
    reset = 1'b1;
    #1;
    chk("mid_rst_state", dut.state, init);
    chk("mid_rst_count", dut.count, 13'd0);
    @(negedge clk);
    reset = 1'b0;
    run_to_finish();

    // Randomized traffic; restart from finish by reset so sequences recur.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 24000; c++) begin
      start    = ($urandom_range(0, 3) == 0);
      doneFSM0 = ($urandom_range(0, 4) == 0);
      doneFSM1 = ($urandom_range(0, 4) == 0);
      if ((m_state == finish && $urandom_range(0, 7) == 0) || $urandom_range(0, 19999) == 0)
        reset = 1'b1;
      else
        reset = 1'b0;
      @(negedge clk);
    end
    reset = 1'b0; start = 1'b0; doneFSM0 = 1'b0; doneFSM1 = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
